// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - fetch controller bus: PC, stall/flush, imem handshake, IF/ID outputs
interface if_fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] i_pc;
    logic              o_pc_write;
    logic              i_stall;
    logic              i_flush;
    logic              o_imem_req;
    logic [ADDR_W-1:0] o_imem_addr;
    logic              i_imem_ack;
    logic [DATA_W-1:0] i_imem_rdata;
    logic              o_ifid_valid;
    logic [DATA_W-1:0] o_ifid_instr;
    logic [ADDR_W-1:0] o_ifid_pc;

    modport master (
        input  i_pc, i_stall, i_flush, i_imem_ack, i_imem_rdata,
        output o_pc_write, o_imem_req, o_imem_addr,
        output o_ifid_valid, o_ifid_instr, o_ifid_pc
    );

    modport slave (
        output i_pc, i_stall, i_flush, i_imem_ack, i_imem_rdata,
        input  o_pc_write, o_imem_req, o_imem_addr,
        input  o_ifid_valid, o_ifid_instr, o_ifid_pc
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch controller with imem req/ack and IF/ID register
module if_fetch_ctrl #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000000
) (
    input  logic          clk,
    input  logic          reset,
    if_fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic              req, req_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              drop, drop_n;
    logic              ifid_valid, ifid_valid_n;
    logic [DATA_W-1:0] ifid_instr, ifid_instr_n;
    logic [ADDR_W-1:0] ifid_pc, ifid_pc_n;
    logic [DATA_W-1:0] buf_instr, buf_instr_n;
    logic [ADDR_W-1:0] buf_pc, buf_pc_n;
    logic              cap;
    logic [DATA_W-1:0] cap_instr;
    logic [ADDR_W-1:0] cap_pc;
    logic              pc_write;

    // State register: FSM, request/address, drop flag, hold buffer and IF/ID
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ISSUE;
            req        <= 1'b0;
            addr       <= '0;
            drop       <= 1'b0;
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= '0;
            buf_instr  <= '0;
            buf_pc     <= '0;
        end else begin
            state      <= state_n;
            req        <= req_n;
            addr       <= addr_n;
            drop       <= drop_n;
            ifid_valid <= ifid_valid_n;
            ifid_instr <= ifid_instr_n;
            ifid_pc    <= ifid_pc_n;
            buf_instr  <= buf_instr_n;
            buf_pc     <= buf_pc_n;
        end
    end

    // Next-state, handshake, PC write enable and IF/ID update priority
    always_comb begin
        state_n      = state;
        req_n        = req;
        addr_n       = addr;
        drop_n       = drop;
        buf_instr_n  = buf_instr;
        buf_pc_n     = buf_pc;
        cap          = 1'b0;
        cap_instr    = bus.i_imem_rdata;
        cap_pc       = addr;
        pc_write     = 1'b0;
        ifid_valid_n = ifid_valid;
        ifid_instr_n = ifid_instr;
        ifid_pc_n    = ifid_pc;

        case (state)
            ST_ISSUE: begin
                // A flush reloads the PC on this edge, so the old i_pc is stale
                if (!bus.i_flush) begin
                    addr_n  = bus.i_pc;
                    req_n   = 1'b1;
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.i_imem_ack) begin
                    req_n   = 1'b0;
                    drop_n  = 1'b0;
                    state_n = ST_ISSUE;
                    if (drop || bus.i_flush) begin
                        // Response belongs to a squashed path: discard it
                    end else if (!bus.i_stall) begin
                        cap       = 1'b1;
                        cap_instr = bus.i_imem_rdata;
                        cap_pc    = addr;
                        pc_write  = 1'b1;
                    end else begin
                        buf_instr_n = bus.i_imem_rdata;
                        buf_pc_n    = addr;
                        state_n     = ST_HOLD;
                    end
                end else if (bus.i_flush) begin
                    // The memory handshake cannot be withdrawn; remember to toss the reply
                    drop_n = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.i_flush) begin
                    state_n = ST_ISSUE;
                end else if (!bus.i_stall) begin
                    cap       = 1'b1;
                    cap_instr = buf_instr;
                    cap_pc    = buf_pc;
                    pc_write  = 1'b1;
                    state_n   = ST_ISSUE;
                end
            end
            default: begin
                state_n = ST_ISSUE;
                req_n   = 1'b0;
            end
        endcase

        if (bus.i_flush) begin
            pc_write = 1'b1;
        end

        if (bus.i_flush) begin
            ifid_valid_n = 1'b0;
            ifid_instr_n = NOP_INSTR;
            ifid_pc_n    = '0;
        end else if (bus.i_stall) begin
            ifid_valid_n = ifid_valid;
        end else if (cap) begin
            ifid_valid_n = 1'b1;
            ifid_instr_n = cap_instr;
            ifid_pc_n    = cap_pc;
        end else begin
            ifid_valid_n = 1'b0;
            ifid_instr_n = NOP_INSTR;
        end
    end

    assign bus.o_pc_write   = pc_write;
    assign bus.o_imem_req   = req;
    assign bus.o_imem_addr  = addr;
    assign bus.o_ifid_valid = ifid_valid;
    assign bus.o_ifid_instr = ifid_instr;
    assign bus.o_ifid_pc    = ifid_pc;

endmodule
